// File: rtl/branch_redirect_unit_pkg.sv
// Shared definitions for the branch redirect unit: FSM states, PC step,
// branch type encodings used by EX, and the word-alignment mask.
package branch_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } br_state_e;

    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        BR_BEQ  = 2'd0,
        BR_BNE  = 2'd1,
        BR_BLEZ = 2'd2,
        BR_BGTZ = 2'd3
    } br_type_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Bundle between EX / hazard logic / instruction fetch and the redirect unit.
// master: the redirect unit; slave: the surrounding pipeline.
interface branch_redirect_unit_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              imem_ready;
    logic              ex_valid;
    logic              ex_is_branch;
    logic              ex_branch_taken;
    logic [ADDR_W-1:0] ex_target;
    logic [ADDR_W-1:0] pc;
    logic              fetch_valid;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              redirect;
    logic              misalign_err;

    modport master (
        input  stall, imem_ready, ex_valid, ex_is_branch, ex_branch_taken, ex_target,
        output pc, fetch_valid, flush_if_id, flush_id_ex, redirect, misalign_err
    );

    modport slave (
        output stall, imem_ready, ex_valid, ex_is_branch, ex_branch_taken, ex_target,
        input  pc, fetch_valid, flush_if_id, flush_id_ex, redirect, misalign_err
    );
endinterface

// File: rtl/branch_redirect_unit_stat_counter.sv
// Saturating event counter used for optional branch statistics.
module branch_stat_counter
    import branch_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count_o = cnt_q;
endmodule

// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: turns a taken EX branch into a PC load plus IF/ID, ID/EX flush.
// Optional statistics counters are enabled with BRANCH_REDIRECT_STATS_EN.
module branch_redirect_unit
    import branch_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] RESET_PC      = '0,
    parameter int                SQUASH_CYCLES = 2,
    parameter int                STAT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_redirect_unit_if.master    bus
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    output logic [STAT_W-1:0]         stat_branches,
    output logic [STAT_W-1:0]         stat_taken
`endif
);
    localparam int CNT_W = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

    br_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_seq_d;
    logic              redirect_q;
    logic              misalign_q;
    logic              fetch_valid_q;
    logic              is_branch;
    logic              take;
    logic              advance;

    // rst_n gate keeps the flushes low while the core is held in reset
    assign is_branch = bus.ex_valid & bus.ex_is_branch & (state_q == RUN);
    assign take      = rst_n & is_branch & bus.ex_branch_taken;
    assign advance   = ~bus.stall & bus.imem_ready;
    assign pc_seq_d  = pc_q + ADDR_W'(PC_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            pc_q          <= RESET_PC;
            redirect_q    <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            fetch_valid_q <= 1'b1;
            redirect_q    <= take;
            case (state_q)
                RUN: begin
                    if (take) begin
                        pc_q    <= {bus.ex_target[ADDR_W-1:2], 2'b00};
                        state_q <= SQUASH;
                        cnt_q   <= CNT_W'(SQUASH_CYCLES - 1);
                        if ((bus.ex_target[1:0] & ALIGN_MASK) != 2'b00) begin
                            misalign_q <= 1'b1;
                        end
                    end else if (advance) begin
                        pc_q <= pc_seq_d;
                    end
                end
                SQUASH: begin
                    if (advance) begin
                        pc_q <= pc_seq_d;
                    end
                    if (cnt_q == '0) begin
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.flush_if_id  = take;
    assign bus.flush_id_ex  = take;
    assign bus.redirect     = redirect_q;
    assign bus.misalign_err = misalign_q;

`ifdef BRANCH_REDIRECT_STATS_EN
    branch_stat_counter #(.W(STAT_W)) u_stat_branches (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (is_branch),
        .count_o (stat_branches)
    );

    branch_stat_counter #(.W(STAT_W)) u_stat_taken (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (take),
        .count_o (stat_taken)
    );
`endif
endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit; stats checks run when
// BRANCH_REDIRECT_STATS_EN is defined.
module tb_branch_redirect_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    branch_redirect_unit_if #(.ADDR_W(32)) bus ();

`ifdef BRANCH_REDIRECT_STATS_EN
    logic [1:0] stat_branches;
    logic [1:0] stat_taken;
`endif

    branch_redirect_unit #(
        .ADDR_W        (32),
        .RESET_PC      (32'h0000_0000),
        .SQUASH_CYCLES (2),
        .STAT_W        (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BRANCH_REDIRECT_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken)
`endif
    );

    task automatic idle();
        bus.stall = 1'b0; bus.imem_ready = 1'b1;
        bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_branch_taken = 1'b0;
        bus.ex_target = '0;
    endtask

    task automatic take_br(input logic [31:0] tgt);
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_branch_taken = 1'b1;
        bus.ex_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        take_br(32'h0000_0040);
        #2;
        n_tests++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        n_tests++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid: got %b want 0", bus.fetch_valid); end
        n_tests++; if (bus.flush_if_id !== 1'b0 || bus.flush_id_ex !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b%b want 00", bus.flush_if_id, bus.flush_id_ex); end
        n_tests++; if (bus.redirect !== 1'b0 || bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: redirect=%b misalign=%b want 0 0", bus.redirect, bus.misalign_err); end
        idle();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.pc !== exp_pc[i] || bus.fetch_valid !== 1'b1 || bus.flush_if_id !== 1'b0) begin
                n_fail++; $display("FAIL seq_pc[%0d]: pc=%h fv=%b flush=%b want pc=%h fv=1 flush=0", i, bus.pc, bus.fetch_valid, bus.flush_if_id, exp_pc[i]);
            end
        end
        tick();
    endtask

    task automatic test_taken_branch();
        n_tests++; if (bus.pc !== 32'h10) begin n_fail++; $display("FAIL tb_start_pc: got %h want %h", bus.pc, 32'h10); end
        take_br(32'h0000_0040);
        #1;
        n_tests++; if (bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1) begin n_fail++; $display("FAIL take_flush: got %b%b want 11", bus.flush_if_id, bus.flush_id_ex); end
        tick();
        n_tests++; if (bus.pc !== 32'h40 || bus.redirect !== 1'b1) begin n_fail++; $display("FAIL take_load: pc=%h redirect=%b want 40 1", bus.pc, bus.redirect); end
        // second taken branch lands inside the squash window
        take_br(32'h0000_0100);
        #1;
        n_tests++; if (bus.flush_if_id !== 1'b0 || bus.flush_id_ex !== 1'b0) begin n_fail++; $display("FAIL squash_flush: got %b%b want 00", bus.flush_if_id, bus.flush_id_ex); end
        tick();
        n_tests++; if (bus.pc !== 32'h44 || bus.redirect !== 1'b0) begin n_fail++; $display("FAIL squash_pc: pc=%h redirect=%b want 44 0", bus.pc, bus.redirect); end
        idle();
        tick();
        n_tests++; if (bus.pc !== 32'h48) begin n_fail++; $display("FAIL squash_pc2: got %h want %h", bus.pc, 32'h48); end
    endtask

    task automatic test_stall_priority();
        take_br(32'h0000_0080);
        bus.stall = 1'b1; bus.imem_ready = 1'b0;
        #1;
        n_tests++; if (bus.flush_if_id !== 1'b1) begin n_fail++; $display("FAIL stall_take_flush: got %b want 1", bus.flush_if_id); end
        tick();
        n_tests++; if (bus.pc !== 32'h80 || bus.redirect !== 1'b1) begin n_fail++; $display("FAIL stall_take_load: pc=%h redirect=%b want 80 1", bus.pc, bus.redirect); end
        bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_branch_taken = 1'b0;
        tick();
        n_tests++; if (bus.pc !== 32'h80 || bus.redirect !== 1'b0) begin n_fail++; $display("FAIL stall_hold1: pc=%h redirect=%b want 80 0", bus.pc, bus.redirect); end
        bus.imem_ready = 1'b1;
        tick();
        n_tests++; if (bus.pc !== 32'h80) begin n_fail++; $display("FAIL stall_hold2: got %h want %h", bus.pc, 32'h80); end
        bus.stall = 1'b0;
        tick();
        n_tests++; if (bus.pc !== 32'h84) begin n_fail++; $display("FAIL stall_release: got %h want %h", bus.pc, 32'h84); end
    endtask

    task automatic test_misalign();
        take_br(32'h0000_0042);
        tick();
        n_tests++; if (bus.pc !== 32'h40 || bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_set: pc=%h err=%b want 40 1", bus.pc, bus.misalign_err); end
        idle();
        repeat (10) tick();
        n_tests++; if (bus.pc !== 32'h68 || bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: pc=%h err=%b want 68 1", bus.pc, bus.misalign_err); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.misalign_err !== 1'b0 || bus.pc !== 32'h0 || bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: err=%b pc=%h fv=%b want 0 0 0", bus.misalign_err, bus.pc, bus.fetch_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_not_taken();
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_branch_taken = 1'b0;
        bus.ex_target = 32'h0000_0200;
        #1;
        n_tests++; if (bus.flush_if_id !== 1'b0) begin n_fail++; $display("FAIL nt_flush: got %b want 0", bus.flush_if_id); end
        tick();
        n_tests++; if (bus.pc !== 32'h4 || bus.redirect !== 1'b0) begin n_fail++; $display("FAIL nt_pc: pc=%h redirect=%b want 4 0", bus.pc, bus.redirect); end
        bus.ex_valid = 1'b0; bus.ex_branch_taken = 1'b1;
        #1;
        n_tests++; if (bus.flush_id_ex !== 1'b0) begin n_fail++; $display("FAIL invalid_flush: got %b want 0", bus.flush_id_ex); end
        tick();
        n_tests++; if (bus.pc !== 32'h8) begin n_fail++; $display("FAIL invalid_pc: got %h want %h", bus.pc, 32'h8); end
        idle();
    endtask

    task automatic test_reset_mid_squash();
        take_br(32'h0000_0300);
        tick();
        n_tests++; if (bus.pc !== 32'h300) begin n_fail++; $display("FAIL ms_load: got %h want %h", bus.pc, 32'h300); end
        idle();
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.pc !== 32'h0 || bus.redirect !== 1'b0) begin n_fail++; $display("FAIL ms_reset: pc=%h redirect=%b want 0 0", bus.pc, bus.redirect); end
        rst_n = 1'b1;
        take_br(32'h0000_0500);
        #1;
        n_tests++; if (bus.flush_if_id !== 1'b1) begin n_fail++; $display("FAIL ms_run_flush: got %b want 1", bus.flush_if_id); end
        tick();
        n_tests++; if (bus.pc !== 32'h500) begin n_fail++; $display("FAIL ms_run_load: got %h want %h", bus.pc, 32'h500); end
        idle();
    endtask

    task automatic test_wrap();
        tick();
        tick();
        take_br(32'hFFFF_FFFC);
        tick();
        n_tests++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_load: got %h want %h", bus.pc, 32'hFFFF_FFFC); end
        idle();
        tick();
        n_tests++; if (bus.pc !== 32'h0 || bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL wrap_pc: pc=%h err=%b want 0 0", bus.pc, bus.misalign_err); end
    endtask

`ifdef BRANCH_REDIRECT_STATS_EN
    task automatic test_stats();
        pulse_reset();
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_branch_taken = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            take_br(32'h0000_0100);
            tick();
            idle();
            repeat (3) tick();
        end
        n_tests++; if (stat_branches !== 2'd3 || stat_taken !== 2'd2) begin n_fail++; $display("FAIL stats_count: branches=%0d taken=%0d want 3 2", stat_branches, stat_taken); end
        for (int i = 0; i < 3; i++) begin
            take_br(32'h0000_0200);
            tick();
            idle();
            repeat (3) tick();
        end
        n_tests++; if (stat_taken !== 2'd3 || stat_branches !== 2'd3) begin n_fail++; $display("FAIL stats_saturate: branches=%0d taken=%0d want 3 3", stat_branches, stat_taken); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_taken_branch();
        test_stall_priority();
        test_misalign();
        test_not_taken();
        test_reset_mid_squash();
        test_wrap();
`ifdef BRANCH_REDIRECT_STATS_EN
        test_stats();
`else
        pulse_reset();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
